// File: rtl/lenet5_stream_loader_pkg.sv
// Shared constants for the LeNet-5 stream loader.
// The beat counts are derived from the network's layer shapes:
//   weights = conv1 (5x5xCI1xCO1) + conv2 (5x5xCI2xCO2) + fc (I_SIZE3^2 x CI3 x CO3)
//   biases  = fc outputs (CO3)
//   pixels  = input image (I_SIZE1^2)
package lenet5_stream_loader_pkg;

  localparam int unsigned I_SIZE1 = 28;
  localparam int unsigned CI1     = 1;
  localparam int unsigned CO1     = 4;
  localparam int unsigned CI2     = 4;
  localparam int unsigned CO2     = 12;
  localparam int unsigned I_SIZE3 = 4;
  localparam int unsigned CI3     = 12;
  localparam int unsigned CO3     = 10;

  localparam int unsigned N_W_DEF   = 25 * CI1 * CO1 + 25 * CI2 * CO2
                                    + I_SIZE3 * I_SIZE3 * CI3 * CO3;
  localparam int unsigned N_B_DEF   = CO3;
  localparam int unsigned N_PIX_DEF = I_SIZE1 * I_SIZE1;

  // Smallest width b with 2^b > n, so a counter of b bits can hold n.
  function automatic int unsigned cnt_bits(input int unsigned n);
    int unsigned b;
    b = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << b) <= 64'(n)) b = b + 1;
    end
    return b;
  endfunction

  localparam int unsigned MAX_BEATS =
    (N_W_DEF > N_PIX_DEF) ? ((N_W_DEF > N_B_DEF) ? N_W_DEF : N_B_DEF)
                          : ((N_PIX_DEF > N_B_DEF) ? N_PIX_DEF : N_B_DEF);
  localparam int unsigned CNT_BW_DEF = cnt_bits(MAX_BEATS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_B,
    ST_LOAD_IMG,
    ST_WAIT_RES,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/lenet5_stream_loader_beat_counter.sv
// Beat counter reused for each load phase.
// Ports:
//   clk, global_rst_n : clock, async active-low reset
//   i_clr             : synchronous clear (priority over increment)
//   i_inc             : increment by one
//   i_last            : terminal count value for the current phase
//   o_tc              : counter currently equals i_last
module lenet5_beat_counter #(
  parameter int unsigned CNT_BW = 12
) (
  input  logic              clk,
  input  logic              global_rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  input  logic [CNT_BW-1:0] i_last,
  output logic              o_tc
);

  logic [CNT_BW-1:0] r_cnt;

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == i_last);

endmodule

// File: rtl/lenet5_stream_loader.sv
// Upstream sequencer for the LeNet-5 top: splits one host valid/ready word
// stream into weights, FC biases and image pixels, drives the top's ce and
// data inputs, then waits for the classification result and pulses the
// process-end reset.
// Ports:
//   clk, global_rst_n          : clock, async active-low reset
//   i_start / i_abort          : begin a run (IDLE only) / abandon a run
//   s_valid, s_data, s_ready   : host word stream
//   o_ce                       : ce to the top, one cycle after each handshake
//   o_weight, o_bias, o_fmap   : data to the top (held between beats)
//   o_rst_processEnd           : one-cycle process-end reset pulse
//   i_class_result/en/end      : classification handshake from the top
//   o_result, o_done, o_busy   : latched class, result-ready pulse, not idle
module lenet5_stream_loader
  import lenet5_stream_loader_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned W_BW   = 8,
  parameter int unsigned B_BW   = 16,
  parameter int unsigned I_BW   = 8,
  parameter int unsigned N_W    = N_W_DEF,
  parameter int unsigned N_B    = N_B_DEF,
  parameter int unsigned N_PIX  = N_PIX_DEF,
  parameter int unsigned CNT_BW = CNT_BW_DEF
) (
  input  logic            clk,
  input  logic            global_rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic            s_valid,
  input  logic [DW-1:0]   s_data,
  output logic            s_ready,
  output logic            o_ce,
  output logic [W_BW-1:0] o_weight,
  output logic [B_BW-1:0] o_bias,
  output logic [I_BW-1:0] o_fmap,
  output logic            o_rst_processEnd,
  input  logic [3:0]      i_class_result,
  input  logic            i_class_en,
  input  logic            i_class_end,
  output logic [3:0]      o_result,
  output logic            o_done,
  output logic            o_busy
);

  state_t            r_state;
  state_t            w_next;
  logic              r_s_ready;
  logic              r_ce;
  logic [W_BW-1:0]   r_w_stage;
  logic              r_w_pend;
  logic [W_BW-1:0]   r_weight;
  logic [B_BW-1:0]   r_b_stage;
  logic              r_b_pend;
  logic [B_BW-1:0]   r_bias;
  logic [I_BW-1:0]   r_fmap;
  logic [3:0]        r_result;
  logic              r_done;
  logic              r_rpe;

  logic              w_loading;
  logic              w_xfer;
  logic              w_abort;
  logic              w_fwd;
  logic              w_tc;
  logic              w_cnt_clr;
  logic              w_cnt_inc;
  logic [CNT_BW-1:0] w_last;

  assign w_loading = (r_state == ST_LOAD_W) || (r_state == ST_LOAD_B) ||
                     (r_state == ST_LOAD_IMG);
  assign w_xfer    = s_valid && r_s_ready;
  assign w_abort   = i_abort && (w_loading || (r_state == ST_WAIT_RES));
  // A handshake coinciding with abort is consumed but never reaches the top.
  assign w_fwd     = w_xfer && !w_abort;

  always_comb begin
    w_last = '0;
    case (r_state)
      ST_LOAD_W:   w_last = CNT_BW'(N_W - 1);
      ST_LOAD_B:   w_last = CNT_BW'(N_B - 1);
      ST_LOAD_IMG: w_last = CNT_BW'(N_PIX - 1);
      default:     w_last = '0;
    endcase
  end

  lenet5_beat_counter #(
    .CNT_BW(CNT_BW)
  ) u_cnt (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .i_clr        (w_cnt_clr),
    .i_inc        (w_cnt_inc),
    .i_last       (w_last),
    .o_tc         (w_tc)
  );

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_clr = 1'b1;
        if (i_start) w_next = ST_LOAD_W;
      end
      ST_LOAD_W, ST_LOAD_B, ST_LOAD_IMG: begin
        if (w_abort) begin
          w_next = ST_CLEAR;
        end else if (w_xfer) begin
          if (w_tc) begin
            w_cnt_clr = 1'b1;
            case (r_state)
              ST_LOAD_W: w_next = ST_LOAD_B;
              ST_LOAD_B: w_next = ST_LOAD_IMG;
              default:   w_next = ST_WAIT_RES;
            endcase
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      ST_WAIT_RES: begin
        if (w_abort || i_class_end) w_next = ST_CLEAR;
      end
      ST_CLEAR: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      r_state   <= ST_IDLE;
      r_s_ready <= 1'b0;
      r_ce      <= 1'b0;
      r_w_stage <= '0;
      r_w_pend  <= 1'b0;
      r_weight  <= '0;
      r_b_stage <= '0;
      r_b_pend  <= 1'b0;
      r_bias    <= '0;
      r_fmap    <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_rpe     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_s_ready <= (w_next == ST_LOAD_W) || (w_next == ST_LOAD_B) ||
                   (w_next == ST_LOAD_IMG);
      r_ce      <= w_fwd;

      // Weight/bias go through a one-beat stage so they trail ce by a cycle;
      // the stage drains independently of state so a phase boundary never
      // swallows the last weight.
      r_w_pend <= w_fwd && (r_state == ST_LOAD_W);
      if (w_fwd && (r_state == ST_LOAD_W)) r_w_stage <= s_data[W_BW-1:0];
      if (r_w_pend) r_weight <= r_w_stage;

      r_b_pend <= w_fwd && (r_state == ST_LOAD_B);
      if (w_fwd && (r_state == ST_LOAD_B)) r_b_stage <= s_data[B_BW-1:0];
      if (r_b_pend) r_bias <= r_b_stage;

      if (w_fwd && (r_state == ST_LOAD_IMG)) r_fmap <= s_data[I_BW-1:0];

      if ((r_state == ST_WAIT_RES) && !i_abort && i_class_en)
        r_result <= i_class_result;
      r_done <= (r_state == ST_WAIT_RES) && !i_abort && i_class_end;
      r_rpe  <= (r_state == ST_CLEAR);
    end
  end

  assign s_ready          = r_s_ready;
  assign o_ce             = r_ce;
  assign o_weight         = r_weight;
  assign o_bias           = r_bias;
  assign o_fmap           = r_fmap;
  assign o_rst_processEnd = r_rpe;
  assign o_result         = r_result;
  assign o_done           = r_done;
  assign o_busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lenet5_stream_loader.sv
module tb_lenet5_stream_loader;

  localparam int NW    = 3220;
  localparam int NB    = 10;
  localparam int NPIX  = 784;
  localparam int TOTAL = NW + NB + NPIX;

  logic        clk = 1'b0;
  logic        global_rst_n;
  logic        i_start, i_abort, s_valid, s_ready;
  logic [15:0] s_data;
  logic        o_ce, o_rst_processEnd, o_done, o_busy;
  logic [7:0]  o_weight, o_fmap;
  logic [15:0] o_bias;
  logic [3:0]  i_class_result, o_result;
  logic        i_class_en, i_class_end;

  always #5 clk = ~clk;

  lenet5_stream_loader #(
    .DW(16), .W_BW(8), .B_BW(16), .I_BW(8),
    .N_W(NW), .N_B(NB), .N_PIX(NPIX), .CNT_BW(12)
  ) dut (
    .clk              (clk),
    .global_rst_n     (global_rst_n),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .o_ce             (o_ce),
    .o_weight         (o_weight),
    .o_bias           (o_bias),
    .o_fmap           (o_fmap),
    .o_rst_processEnd (o_rst_processEnd),
    .i_class_result   (i_class_result),
    .i_class_en       (i_class_en),
    .i_class_end      (i_class_end),
    .o_result         (o_result),
    .o_done           (o_done),
    .o_busy           (o_busy)
  );

  int nerr = 0;
  int nchk = 0;

  // Behavioural model: run bookkeeping by total beats taken in this run.
  bit          m_load, m_wait, m_clear;
  int          m_beats;
  logic        e_ready, e_ce, e_rpe, e_done, e_busy;
  logic [7:0]  e_w, e_f, pw;
  logic [15:0] e_b, pb;
  logic [3:0]  e_res;
  bit          pw_v, pb_v;

  // Observations of the DUT used for the literal checks.
  int          ce_cnt, done_cnt;
  bit          cap_w0_p, cap_wl_p, cap_b_p;
  logic [7:0]  cap_w0, cap_wl, cap_f;
  logic [15:0] cap_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load = 0; m_wait = 0; m_clear = 0; m_beats = 0;
    e_ready = 0; e_ce = 0; e_rpe = 0; e_done = 0; e_busy = 0;
    e_w = '0; e_f = '0; e_b = '0; e_res = '0; pw = '0; pb = '0;
    pw_v = 0; pb_v = 0;
    cap_w0_p = 0; cap_wl_p = 0; cap_b_p = 0;
  endtask

  // Compare outputs against the model, then advance the model with the
  // inputs that the coming rising edge will sample.
  task automatic compare_and_step();
    bit hs, ab;
    if (!global_rst_n) begin
      model_reset();
      return;
    end
    chk("s_ready", s_ready, e_ready);
    chk("o_ce", o_ce, e_ce);
    chk("o_weight", o_weight, e_w);
    chk("o_bias", o_bias, e_b);
    chk("o_fmap", o_fmap, e_f);
    chk("o_rst_processEnd", o_rst_processEnd, e_rpe);
    chk("o_result", o_result, e_res);
    chk("o_done", o_done, e_done);
    chk("o_busy", o_busy, e_busy);

    if (cap_w0_p) cap_w0 = o_weight;
    if (cap_wl_p) cap_wl = o_weight;
    if (cap_b_p)  cap_b  = o_bias;
    cap_w0_p = 0; cap_wl_p = 0; cap_b_p = 0;
    if (o_done) done_cnt++;
    if (o_ce) begin
      ce_cnt++;
      if (ce_cnt == 1)         cap_w0_p = 1;
      if (ce_cnt == NW)        cap_wl_p = 1;
      if (ce_cnt == NW + 1)    cap_b_p  = 1;
      if (ce_cnt == NW + NB + 1) cap_f  = o_fmap;
    end

    hs = s_valid && e_ready;
    ab = i_abort && (m_load || m_wait);
    if (pw_v) e_w = pw;
    if (pb_v) e_b = pb;
    pw_v = 0; pb_v = 0;
    e_ce = hs && !ab;
    e_done = 0; e_rpe = 0;
    if (hs && !ab) begin
      if (m_beats < NW) begin pw = s_data[7:0]; pw_v = 1; end
      else if (m_beats < NW + NB) begin pb = s_data; pb_v = 1; end
      else e_f = s_data[7:0];
      m_beats++;
    end
    if (m_clear) begin
      m_clear = 0; e_rpe = 1;
    end else if (ab) begin
      m_load = 0; m_wait = 0; m_clear = 1;
    end else if (m_load) begin
      if (m_beats == TOTAL) begin m_load = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (i_class_en) e_res = i_class_result;
      if (i_class_end) begin m_wait = 0; m_clear = 1; e_done = 1; end
    end else if (i_start) begin
      m_load = 1; m_beats = 0; ce_cnt = 0;
    end
    e_ready = m_load;
    e_busy = m_load || m_wait || m_clear;
  endtask

  // One clock: check at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_and_step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      bit took;
      int guard;
      if (stall) begin s_valid = 0; tick(); end
      s_valid = 1;
      s_data = 16'(i);
      took = 0;
      guard = 0;
      while (!took) begin
        took = s_ready;
        tick();
        guard++;
        if (!took && guard > 20) begin
          nchk++; nerr++;
          $display("FAIL feed_timeout: beat %0d never accepted", i);
          s_valid = 0;
          return;
        end
      end
    end
    s_valid = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_o_ce"}, o_ce, 0);
    chk({tag, "_o_weight"}, o_weight, 0);
    chk({tag, "_o_bias"}, o_bias, 0);
    chk({tag, "_o_fmap"}, o_fmap, 0);
    chk({tag, "_o_rst_processEnd"}, o_rst_processEnd, 0);
    chk({tag, "_o_result"}, o_result, 0);
    chk({tag, "_o_done"}, o_done, 0);
    chk({tag, "_o_busy"}, o_busy, 0);
  endtask

  initial begin
    global_rst_n = 0;
    i_start = 0; i_abort = 0; s_valid = 0; s_data = '0;
    i_class_result = '0; i_class_en = 0; i_class_end = 0;
    ce_cnt = 0; done_cnt = 0;
    cap_w0 = '0; cap_wl = '0; cap_b = '0; cap_f = '0;
    model_reset();
    tick(); tick();
    chk_all_zero("reset");
    global_rst_n = 1;

    // Idle with valid data but no start: nothing is accepted.
    s_valid = 1; s_data = 16'h1234;
    for (int i = 0; i < 100; i++) tick();
    chk("idle_s_ready", s_ready, 0);
    chk("idle_o_ce", o_ce, 0);
    s_valid = 0;

    // Back-to-back full load.
    i_start = 1; tick(); i_start = 0;
    feed(TOTAL, 0);
    tick();
    chk("run1_ce_beats", ce_cnt, 4014);
    chk("run1_last_weight", cap_wl, 8'h93);
    chk("run1_first_bias", cap_b, 16'h0C94);
    chk("run1_first_pixel", cap_f, 8'h9E);
    chk("run1_ready_after", s_ready, 0);
    chk("run1_busy_wait", o_busy, 1);

    // Result, then end five cycles later.
    i_class_en = 1; i_class_result = 4'd7; tick();
    i_class_en = 0; i_class_result = 4'd0;
    for (int i = 0; i < 4; i++) tick();
    i_class_end = 1; tick(); i_class_end = 0;
    chk("run1_done", o_done, 1);
    chk("run1_result", o_result, 4'd7);
    chk("run1_rpe_early", o_rst_processEnd, 0);
    tick();
    chk("run1_done_gone", o_done, 0);
    chk("run1_rpe", o_rst_processEnd, 1);
    chk("run1_idle", o_busy, 0);
    tick();
    chk("run1_rpe_gone", o_rst_processEnd, 0);

    // Stalled load, then coincident class_en/class_end.
    i_start = 1; tick(); i_start = 0;
    feed(TOTAL, 1);
    tick();
    chk("run2_ce_beats", ce_cnt, 4014);
    chk("run2_last_weight", cap_wl, 8'h93);
    chk("run2_first_bias", cap_b, 16'h0C94);
    chk("run2_first_pixel", cap_f, 8'h9E);
    i_class_en = 1; i_class_end = 1; i_class_result = 4'd3; tick();
    i_class_en = 0; i_class_end = 0; i_class_result = 4'd0;
    chk("run2_result", o_result, 4'd3);
    tick(); tick();
    chk("run2_done_cnt", done_cnt, 2);

    // Abort after 500 weights, with a transfer coinciding with the abort.
    i_start = 1; tick(); i_start = 0;
    feed(500, 0);
    s_valid = 1; s_data = 16'd500; i_abort = 1; tick();
    s_valid = 0; i_abort = 0;
    chk("abort_ce", o_ce, 0);
    chk("abort_busy_clear", o_busy, 1);
    tick();
    chk("abort_rpe", o_rst_processEnd, 1);
    chk("abort_idle", o_busy, 0);
    chk("abort_weight_held", o_weight, 8'hF3);
    tick();
    chk("abort_done_cnt", done_cnt, 2);
    chk("abort_result_kept", o_result, 4'd3);

    // Fresh start restarts at weight 0; reset mid-image.
    i_start = 1; tick(); i_start = 0;
    feed(NW + NB + 20, 0);
    chk("run3_first_weight", cap_w0, 8'h00);
    chk("run3_last_weight", cap_wl, 8'h93);
    global_rst_n = 0;
    #1;
    chk_all_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_rpe", o_rst_processEnd, 0);
    end
    global_rst_n = 1;
    tick();
    chk("post_rst_rpe", o_rst_processEnd, 0);
    i_start = 1; tick(); i_start = 0;
    chk("post_rst_ready", s_ready, 1);
    chk("post_rst_busy", o_busy, 1);
    i_abort = 1; tick(); i_abort = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/lenet5_stream_loader.md
Name: lenet5_stream_loader

Overview:
- Upstream sequencer for the LeNet-5 top. Accepts one valid/ready word stream from the host and splits it into three phases, in order: FC/conv weights, FC biases, then input-image pixels.
- Drives the top's ce, weight, bias and fmap inputs with the required timing.
- Waits for the classification-end pulse, captures the class, then pulses the process-end reset so the next image can be loaded.

Parameters:
- DW, 16, host stream word width
- W_BW, 8, weight width (low W_BW bits of word)
- B_BW, 16, bias width (low B_BW bits of word)
- I_BW, 8, pixel width (low I_BW bits of word)
- N_W, 3220, weight beats per image
- N_B, 10, bias beats per image
- N_PIX, 784, pixel beats per image (28x28)
- CNT_BW, 12, counter width, must satisfy 2^CNT_BW > max(N_W,N_B,N_PIX)

Ports:
- clk  in  1  clock
- global_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  begin one image load+inference; sampled in IDLE only
- i_abort  in  1  abandon current run from any non-IDLE state
- s_valid  in  1  host word valid
- s_data  in  DW  host word
- s_ready  out  1  loader accepts word
- o_ce  out  1  ce to the LeNet-5 top
- o_weight  out  W_BW  weight to top (signed)
- o_bias  out  B_BW  FC bias to top (signed)
- o_fmap  out  I_BW  pixel to top (signed)
- o_rst_processEnd  out  1  one-cycle process-end reset pulse
- i_class_result  in  4  classification result from top
- i_class_en  in  1  result valid from top
- i_class_end  in  1  inference finished, from top
- o_result  out  4  latched class
- o_done  out  1  one-cycle pulse, result ready
- o_busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, counter 0. All outputs 0: s_ready, o_ce, o_weight, o_bias, o_fmap, o_rst_processEnd, o_result, o_done, o_busy.
- Transfer occurs when s_valid && s_ready. s_ready is a registered function of state and is 1 only in LOAD_W, LOAD_B, LOAD_IMG.
- o_ce is registered and equals "transfer this cycle" in any load state, so it asserts 1 cycle after the handshake. Host stalls (s_valid=0) give o_ce=0, and the top sees gaps.
- Data alignment. The top re-registers ce for its weight/bias buffers but uses ce directly for conv1:
  - LOAD_W / LOAD_B: o_weight / o_bias update 1 cycle after o_ce, i.e. 2 cycles after the handshake, and hold until the next update.
  - LOAD_IMG: o_fmap updates in the same cycle o_ce asserts.
  - Held outputs keep their last value and are never zeroed between beats.
- FSM:
  - IDLE: on i_start, go to LOAD_W with cnt=0.
  - LOAD_W: per transfer cnt++. On the transfer with cnt==N_W-1, go to LOAD_B with cnt=0.
  - LOAD_B: same, with N_B, then go to LOAD_IMG.
  - LOAD_IMG: same, with N_PIX, then go to WAIT_RES.
  - WAIT_RES: s_ready=0. On i_class_en, latch i_class_result into o_result. On i_class_end, go to CLEAR and assert o_done for 1 cycle. If i_class_en and i_class_end coincide, latch that same cycle.
  - CLEAR: o_rst_processEnd=1 for exactly 1 cycle, then go to IDLE.
- i_abort in LOAD_* or WAIT_RES: go to CLEAR next cycle. s_ready drops the same edge, so a transfer coinciding with abort is accepted but not forwarded (o_ce=0 afterwards), o_done stays 0, and o_result is unchanged.
- i_abort in IDLE or CLEAR is ignored. i_start outside IDLE is ignored.
- i_class_* outside WAIT_RES is ignored.
- Pending delayed weight/bias update at a phase boundary must still be emitted: last weight at cycle t+2, first bias later.
- Async reset mid-operation returns to IDLE with no o_rst_processEnd pulse. The top shares global_rst_n, so it is reset too.

Decomposition:
- Shared package/header: the N_W, N_B, N_PIX constants derived from the layer parameters (25·CI1·CO1 + 25·CI2·CO2 + I_SIZE3²·CI3·CO3, CO3, I_SIZE1²), the state encoding, and the CNT_BW clog2 helper.
- One sub-module is natural: lenet5_beat_counter, a load/increment/terminal-count counter reused per phase.

Test Plan:
- Reset then idle, s_valid=1 with no i_start -> s_ready=0, o_ce=0, all outputs 0 for 100 cycles.
- i_start, then 3220+10+784 back-to-back words (value=index) -> o_ce high for 4014 beats. Last weight 0x93 (3219 mod 256) appears 1 cycle after its o_ce. First bias 0x0C94 follows. First pixel 0x9E appears coincident with its o_ce. s_ready=0 after beat 4014.
- Same run with s_valid toggling 1/0 -> beat count unchanged, o_ce gaps mirror stalls, values in order.
- In WAIT_RES drive i_class_en with result 7, then i_class_end 5 cycles later -> o_result=7, o_done 1 cycle, o_rst_processEnd 1 cycle on the next cycle, then IDLE.
- i_abort after 500 weight beats -> CLEAR pulse, IDLE, o_done=0, o_result unchanged. A fresh i_start then restarts at weight beat 0.
- Assert global_rst_n=0 during LOAD_IMG -> all outputs 0 immediately, no o_rst_processEnd pulse, and i_start is accepted after release.
